// File: rtl/fp_sqrt_sequencer_if.sv
// Bundle of the operand, result and FP_SQRT core signals of the sqrt sequencer.
//
// Handshake rule for both the operand and the result channel: a transfer
// happens on a rising clk edge where valid and ready are both high. valid
// must not depend on ready. Once raised, valid and its data stay stable until
// that transfer edge.
//
// The master modport is the sequencer side. The slave modport is its environment:
// the upstream datapath, the downstream consumer and the FP_SQRT core.
interface fp_sqrt_sequencer_if #(
  parameter int DATAWIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATAWIDTH-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATAWIDTH-1:0] out_data;
  logic                 out_special;
  logic                 sqrt_start;
  logic [DATAWIDTH-1:0] sqrt_data_o;
  logic [DATAWIDTH-1:0] sqrt_data_i;

  modport master (
    input  in_valid, in_data, out_ready, sqrt_data_i,
    output in_ready, out_valid, out_data, out_special, sqrt_start, sqrt_data_o
  );

  modport slave (
    output in_valid, in_data, out_ready, sqrt_data_i,
    input  in_ready, out_valid, out_data, out_special, sqrt_start, sqrt_data_o
  );
endinterface

// File: rtl/fp_sqrt_sequencer.sv
// Issue/capture stage in front of the multi-cycle FP_SQRT core.
// Zero, denormal, infinite, NaN and negative operands are answered locally.
// Normal operands are sent to the core with a start strobe. The core result
// is captured after a fixed wait. One operation is in flight at a time.
// Every output is a register. The output registers are loaded from the next
// state, so an output changes on the same edge as the state.
module fp_sqrt_sequencer #(
  parameter int DATAWIDTH    = 32,
  parameter int START_CYCLES = 2,
  parameter int WAIT_CYCLES  = 50
) (
  input  logic                clk,
  input  logic                rst,
  fp_sqrt_sequencer_if.master bus,
  output logic [1:0]          state_dbg
);

  localparam int MAX_CYCLES = (START_CYCLES > WAIT_CYCLES) ? START_CYCLES : WAIT_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] START_LOAD = CW'(START_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LOAD  = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_next;
  logic                 accept;
  logic                 cnt_zero;
  logic                 capture;
  logic                 op_sign;
  logic [7:0]           op_exp;
  logic [22:0]          op_frac;
  logic                 op_special;
  logic [DATAWIDTH-1:0] special_result;
  logic                 in_ready_next;
  logic                 out_valid_next;
  logic                 sqrt_start_next;

  assign state_dbg = state;
  assign accept    = bus.in_valid && bus.in_ready;
  assign cnt_zero  = (cnt == '0);
  assign capture   = (state == WAIT) && cnt_zero;
  assign op_sign   = bus.in_data[31];
  assign op_exp    = bus.in_data[30:23];
  assign op_frac   = bus.in_data[22:0];

  // Classify the incoming operand and form the locally resolved result.
  // NaN is tested before the sign, so a negative NaN keeps its payload and
  // is quieted. It does not become the default NaN.
  always_comb begin
    op_special     = 1'b1;
    special_result = '0;
    if (op_exp == 8'h00) begin
      special_result = {op_sign, 31'b0};
    end else if ((op_exp == 8'hFF) && (op_frac != 23'b0)) begin
      special_result = {op_sign, 8'hFF, 1'b1, op_frac[21:0]};
    end else if (op_sign) begin
      special_result = 32'h7FC0_0000;
    end else if (op_exp == 8'hFF) begin
      special_result = 32'h7F80_0000;
    end else begin
      op_special = 1'b0;
    end
  end

  // State and phase counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic. The counter is reloaded on each entry to a timed phase.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (op_special) begin
            state_next = DONE;
          end else begin
            state_next = START;
            cnt_next   = START_LOAD;
          end
        end
      end
      START: begin
        if (cnt_zero) begin
          state_next = WAIT;
          cnt_next   = WAIT_LOAD;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      WAIT: begin
        if (cnt_zero) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode. It gives the value each control output will hold in the next state.
  always_comb begin
    in_ready_next   = (state_next == IDLE);
    out_valid_next  = (state_next == DONE);
    sqrt_start_next = (state_next == START);
  end

  // Output registers. The result and the core operand are loaded only on
  // their own events, so they stay stable through backpressure. The core
  // operand also stays stable after the operation completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.in_ready    <= 1'b0;
      bus.out_valid   <= 1'b0;
      bus.sqrt_start  <= 1'b0;
      bus.out_data    <= '0;
      bus.out_special <= 1'b0;
      bus.sqrt_data_o <= '0;
    end else begin
      bus.in_ready   <= in_ready_next;
      bus.out_valid  <= out_valid_next;
      bus.sqrt_start <= sqrt_start_next;
      if ((state == IDLE) && accept) begin
        if (op_special) begin
          bus.out_data    <= special_result;
          bus.out_special <= 1'b1;
        end else begin
          bus.sqrt_data_o <= bus.in_data;
        end
      end
      if (capture) begin
        bus.out_data    <= bus.sqrt_data_i;
        bus.out_special <= 1'b0;
      end
    end
  end

endmodule
